// File: rtl/idli_insn_deser_m.sv
// Instruction deserialiser: assembles LANE_W-bit serial beats into WORD_W-bit
// instruction words, attaches an optional trailing immediate, and buffers
// complete entries in a DEPTH-deep first-word-fall-through FIFO.
module idli_insn_deser_m #(
  parameter int unsigned LANE_W    = 4,
  parameter int unsigned WORD_W    = 16,
  parameter int unsigned DEPTH     = 2,
  parameter bit          MSB_FIRST = 1'b1,
  parameter bit          IMM_EN    = 1'b1
) (
  input  logic                           i_ids_gck,
  input  logic                           i_ids_rst,
  input  logic [LANE_W-1:0]              i_ids_enc,
  input  logic                           i_ids_enc_vld,
  output logic                           o_ids_enc_rdy,
  input  logic                           i_ids_flush,
  output logic                           o_ids_vld,
  input  logic                           i_ids_rdy,
  output logic [WORD_W-1:0]              o_ids_insn,
  output logic [WORD_W-1:0]              o_ids_imm,
  output logic                           o_ids_imm_vld,
  output logic [$clog2(DEPTH+1)-1:0]     o_ids_cnt
);

  localparam int unsigned BEATS  = WORD_W / LANE_W;
  localparam int unsigned CNT_W  = $clog2(DEPTH + 1);
  localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned BCNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic [0:0] {
    S_INSN = 1'b0,
    S_IMM  = 1'b1
  } state_t;

  state_t              state_q;
  logic [BCNT_W-1:0]   beat_q;
  logic [WORD_W-1:0]   shreg_q;
  logic [WORD_W-1:0]   pend_q;
  logic [WORD_W-1:0]   asm_word;

  logic [WORD_W-1:0]   insn_mem [DEPTH];
  logic [WORD_W-1:0]   imm_mem  [DEPTH];
  logic                immv_mem [DEPTH];
  logic [PTR_W-1:0]    wptr_q;
  logic [PTR_W-1:0]    rptr_q;
  logic [CNT_W-1:0]    cnt_q;

  logic                beat_acc;
  logic                last_beat;
  logic                has_imm;
  logic                push;
  logic                pop;
  logic [WORD_W-1:0]   push_insn;
  logic [WORD_W-1:0]   push_imm;
  logic                push_immv;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Ready depends only on registered occupancy, never on the consumer side.
  assign o_ids_enc_rdy = (cnt_q != CNT_W'(DEPTH));
  assign o_ids_vld     = (cnt_q != '0);
  assign o_ids_cnt     = cnt_q;
  assign o_ids_insn    = insn_mem[rptr_q];
  assign o_ids_imm     = imm_mem[rptr_q];
  assign o_ids_imm_vld = immv_mem[rptr_q];

  assign beat_acc  = i_ids_enc_vld & o_ids_enc_rdy & ~i_ids_flush;
  assign last_beat = (beat_q == BCNT_W'(BEATS - 1));
  assign pop       = o_ids_vld & i_ids_rdy & ~i_ids_flush;

  // Word as it stands with the current beat shifted in.
  always_comb begin
    asm_word = '0;
    if (MSB_FIRST) begin
      asm_word = (shreg_q << LANE_W) | WORD_W'(i_ids_enc);
    end else begin
      asm_word = (shreg_q >> LANE_W) | (WORD_W'(i_ids_enc) << (WORD_W - LANE_W));
    end
  end

  // Decide whether the last beat completes an entry and what that entry holds.
  always_comb begin
    has_imm   = IMM_EN && (asm_word[2:0] == 3'b111);
    push      = 1'b0;
    push_insn = asm_word;
    push_imm  = '0;
    push_immv = 1'b0;
    if (beat_acc && last_beat) begin
      if (state_q == S_IMM) begin
        push      = 1'b1;
        push_insn = pend_q;
        push_imm  = asm_word;
        push_immv = 1'b1;
      end else if (!has_imm) begin
        push      = 1'b1;
      end
    end
  end

  // Assembly FSM: beat counter, shift register and pending instruction.
  always_ff @(posedge i_ids_gck or posedge i_ids_rst) begin
    if (i_ids_rst) begin
      state_q <= S_INSN;
      beat_q  <= '0;
      shreg_q <= '0;
      pend_q  <= '0;
    end else if (i_ids_flush) begin
      state_q <= S_INSN;
      beat_q  <= '0;
      pend_q  <= '0;
    end else if (beat_acc) begin
      shreg_q <= asm_word;
      if (last_beat) begin
        beat_q <= '0;
        case (state_q)
          S_INSN: begin
            if (has_imm) begin
              pend_q  <= asm_word;
              state_q <= S_IMM;
            end
          end
          S_IMM: begin
            state_q <= S_INSN;
          end
          default: state_q <= S_INSN;
        endcase
      end else begin
        beat_q <= beat_q + 1'b1;
      end
    end
  end

  // FIFO pointers and occupancy; flush wins over push and pop.
  always_ff @(posedge i_ids_gck or posedge i_ids_rst) begin
    if (i_ids_rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else if (i_ids_flush) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push) wptr_q <= ptr_inc(wptr_q);
      if (pop)  rptr_q <= ptr_inc(rptr_q);
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // FIFO storage write at the write pointer.
  always_ff @(posedge i_ids_gck or posedge i_ids_rst) begin
    if (i_ids_rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        insn_mem[i] <= '0;
        imm_mem[i]  <= '0;
        immv_mem[i] <= 1'b0;
      end
    end else if (push) begin
      insn_mem[wptr_q] <= push_insn;
      imm_mem[wptr_q]  <= push_imm;
      immv_mem[wptr_q] <= push_immv;
    end
  end

endmodule

// File: tb/tb_idli_insn_deser_m.sv
// Bench for idli_insn_deser_m: default instance, an IMM_EN=0 instance sharing
// its stimulus, and a 1-bit LSB-first instance.
module tb_idli_insn_deser_m;

  typedef struct packed {
    logic [15:0] insn;
    logic [15:0] imm;
    logic        immv;
  } ent_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic [3:0]  enc_a = '0;
  logic        vld_a = 1'b0;
  logic        flush_a = 1'b0;
  logic        rdy_a = 1'b1;
  logic        enc_rdy_a, ovld_a, immv_a;
  logic [15:0] insn_a, imm_a;
  logic [1:0]  cnt_a;

  logic        enc_rdy_b, ovld_b, immv_b;
  logic [15:0] insn_b, imm_b;
  logic [1:0]  cnt_b;

  logic [0:0]  enc_c = '0;
  logic        vld_c = 1'b0;
  logic        flush_c = 1'b0;
  logic        rdy_c = 1'b1;
  logic        enc_rdy_c, ovld_c, immv_c;
  logic [15:0] insn_c, imm_c;
  logic [1:0]  cnt_c;

  ent_t qa[$];
  ent_t qb[$];
  ent_t qc[$];
  ent_t ea, eb, ec;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  idli_insn_deser_m #(.LANE_W(4), .WORD_W(16), .DEPTH(2), .MSB_FIRST(1'b1), .IMM_EN(1'b1)) u_dut_a (
    .i_ids_gck(clk), .i_ids_rst(rst), .i_ids_enc(enc_a), .i_ids_enc_vld(vld_a),
    .o_ids_enc_rdy(enc_rdy_a), .i_ids_flush(flush_a), .o_ids_vld(ovld_a), .i_ids_rdy(rdy_a),
    .o_ids_insn(insn_a), .o_ids_imm(imm_a), .o_ids_imm_vld(immv_a), .o_ids_cnt(cnt_a));

  idli_insn_deser_m #(.LANE_W(4), .WORD_W(16), .DEPTH(2), .MSB_FIRST(1'b1), .IMM_EN(1'b0)) u_dut_b (
    .i_ids_gck(clk), .i_ids_rst(rst), .i_ids_enc(enc_a), .i_ids_enc_vld(vld_a),
    .o_ids_enc_rdy(enc_rdy_b), .i_ids_flush(flush_a), .o_ids_vld(ovld_b), .i_ids_rdy(rdy_a),
    .o_ids_insn(insn_b), .o_ids_imm(imm_b), .o_ids_imm_vld(immv_b), .o_ids_cnt(cnt_b));

  idli_insn_deser_m #(.LANE_W(1), .WORD_W(16), .DEPTH(2), .MSB_FIRST(1'b0), .IMM_EN(1'b1)) u_dut_c (
    .i_ids_gck(clk), .i_ids_rst(rst), .i_ids_enc(enc_c), .i_ids_enc_vld(vld_c),
    .o_ids_enc_rdy(enc_rdy_c), .i_ids_flush(flush_c), .o_ids_vld(ovld_c), .i_ids_rdy(rdy_c),
    .o_ids_insn(insn_c), .o_ids_imm(imm_c), .o_ids_imm_vld(immv_c), .o_ids_cnt(cnt_c));

  // One beat on the shared A/B lane, waiting (bounded) for ready.
  task automatic beat_a(input logic [3:0] v);
    int unsigned n;
    n = 0;
    enc_a = v;
    vld_a = 1'b1;
    @(negedge clk);
    while (!enc_rdy_a && n < 50) begin
      n++;
      @(negedge clk);
    end
    n_checks++;
    if (enc_rdy_a !== 1'b1) begin
      n_fail++;
      $display("FAIL beat_a_timeout: enc_rdy=%b required 1", enc_rdy_a);
    end
    @(posedge clk);
    #1;
    vld_a = 1'b0;
    enc_a = 'x;
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    n_checks += 7;
    if (ovld_a !== 1'b0)     begin n_fail++; $display("FAIL rst_vld: got %b required 0", ovld_a); end
    if (insn_a !== 16'h0)    begin n_fail++; $display("FAIL rst_insn: got %h required 0000", insn_a); end
    if (imm_a !== 16'h0)     begin n_fail++; $display("FAIL rst_imm: got %h required 0000", imm_a); end
    if (immv_a !== 1'b0)     begin n_fail++; $display("FAIL rst_imm_vld: got %b required 0", immv_a); end
    if (cnt_a !== 2'd0)      begin n_fail++; $display("FAIL rst_cnt: got %0d required 0", cnt_a); end
    if (enc_rdy_a !== 1'b1)  begin n_fail++; $display("FAIL rst_enc_rdy: got %b required 1", enc_rdy_a); end
    if (enc_rdy_c !== 1'b1)  begin n_fail++; $display("FAIL rst_enc_rdy_c: got %b required 1", enc_rdy_c); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    rdy_a = 1'b1;
    qa.push_back('{16'h1234, 16'h0, 1'b0});
    qb.push_back('{16'h1234, 16'h0, 1'b0});
    beat_a(4'h1); beat_a(4'h2); beat_a(4'h3); beat_a(4'h4);
    n_checks += 3;
    if (ovld_a !== 1'b1)    begin n_fail++; $display("FAIL basic_vld: got %b required 1", ovld_a); end
    if (insn_a !== 16'h1234) begin n_fail++; $display("FAIL basic_insn: got %h required 1234", insn_a); end
    if (cnt_a !== 2'd1)     begin n_fail++; $display("FAIL basic_cnt1: got %0d required 1", cnt_a); end
    idle(1);
    n_checks++;
    if (cnt_a !== 2'd0)     begin n_fail++; $display("FAIL basic_cnt0: got %0d required 0", cnt_a); end
  endtask

  task automatic test_imm();
    rdy_a = 1'b1;
    qa.push_back('{16'hABCF, 16'hDEAD, 1'b1});
    qb.push_back('{16'hABCF, 16'h0, 1'b0});
    qb.push_back('{16'hDEAD, 16'h0, 1'b0});
    beat_a(4'hA); beat_a(4'hB); beat_a(4'hC); beat_a(4'hF);
    n_checks += 2;
    if (cnt_a !== 2'd0) begin n_fail++; $display("FAIL imm_no_push: cnt got %0d required 0", cnt_a); end
    if (cnt_b !== 2'd1) begin n_fail++; $display("FAIL noimm_push: cnt got %0d required 1", cnt_b); end
    beat_a(4'hD); beat_a(4'hE); beat_a(4'hA); beat_a(4'hD);
    n_checks += 2;
    if (immv_a !== 1'b1)    begin n_fail++; $display("FAIL imm_vld: got %b required 1", immv_a); end
    if (imm_a !== 16'hDEAD) begin n_fail++; $display("FAIL imm_word: got %h required dead", imm_a); end
    idle(2);
  endtask

  task automatic test_lsb_first();
    logic [15:0] w;
    w = 16'h8001;
    qc.push_back('{16'h8001, 16'h0, 1'b0});
    for (int i = 0; i < 16; i++) begin
      enc_c = w[i];
      vld_c = 1'b1;
      @(negedge clk);
      n_checks++;
      if (enc_rdy_c !== 1'b1) begin n_fail++; $display("FAIL lsb_enc_rdy beat %0d: got %b required 1", i, enc_rdy_c); end
      @(posedge clk);
      #1;
    end
    vld_c = 1'b0;
    enc_c = 'x;
    n_checks += 2;
    if (ovld_c !== 1'b1)     begin n_fail++; $display("FAIL lsb_vld: got %b required 1", ovld_c); end
    if (insn_c !== 16'h8001) begin n_fail++; $display("FAIL lsb_insn: got %h required 8001", insn_c); end
    idle(2);
  endtask

  task automatic test_back_to_back();
    rdy_a = 1'b0;
    qa.push_back('{16'h1111, 16'h0, 1'b0});
    qa.push_back('{16'h2222, 16'h0, 1'b0});
    qa.push_back('{16'h3333, 16'h0, 1'b0});
    qb.push_back('{16'h1111, 16'h0, 1'b0});
    qb.push_back('{16'h2222, 16'h0, 1'b0});
    qb.push_back('{16'h3333, 16'h0, 1'b0});
    for (int i = 0; i < 4; i++) beat_a(4'h1);
    for (int i = 0; i < 4; i++) beat_a(4'h2);
    n_checks += 2;
    if (cnt_a !== 2'd2)     begin n_fail++; $display("FAIL full_cnt: got %0d required 2", cnt_a); end
    if (enc_rdy_a !== 1'b0) begin n_fail++; $display("FAIL full_enc_rdy: got %b required 0", enc_rdy_a); end
    enc_a = 4'h3;
    vld_a = 1'b1;
    repeat (3) begin
      @(negedge clk);
      n_checks += 3;
      if (enc_rdy_a !== 1'b0)  begin n_fail++; $display("FAIL stall_enc_rdy: got %b required 0", enc_rdy_a); end
      if (insn_a !== 16'h1111) begin n_fail++; $display("FAIL stall_head: got %h required 1111", insn_a); end
      if (cnt_a !== 2'd2)      begin n_fail++; $display("FAIL stall_cnt: got %0d required 2", cnt_a); end
    end
    @(posedge clk);
    #1;
    rdy_a = 1'b1;
    for (int i = 0; i < 4; i++) beat_a(4'h3);
    idle(3);
    n_checks++;
    if (cnt_a !== 2'd0) begin n_fail++; $display("FAIL drain_cnt: got %0d required 0", cnt_a); end
  endtask

  task automatic test_flush();
    rdy_a = 1'b0;
    beat_a(4'h9); beat_a(4'h9); beat_a(4'h9); beat_a(4'h0);
    n_checks++;
    if (cnt_a !== 2'd1) begin n_fail++; $display("FAIL pre_flush_cnt: got %0d required 1", cnt_a); end
    beat_a(4'h1); beat_a(4'h2);
    flush_a = 1'b1;
    vld_a = 1'b1;
    enc_a = 4'h3;
    @(posedge clk);
    #1;
    flush_a = 1'b0;
    vld_a = 1'b0;
    enc_a = 'x;
    n_checks += 3;
    if (cnt_a !== 2'd0)     begin n_fail++; $display("FAIL flush_cnt: got %0d required 0", cnt_a); end
    if (ovld_a !== 1'b0)    begin n_fail++; $display("FAIL flush_vld: got %b required 0", ovld_a); end
    if (cnt_b !== 2'd0)     begin n_fail++; $display("FAIL flush_cnt_b: got %0d required 0", cnt_b); end
    rdy_a = 1'b1;
    qa.push_back('{16'h5678, 16'h0, 1'b0});
    qb.push_back('{16'h5678, 16'h0, 1'b0});
    beat_a(4'h5); beat_a(4'h6); beat_a(4'h7); beat_a(4'h8);
    n_checks++;
    if (insn_a !== 16'h5678) begin n_fail++; $display("FAIL post_flush_insn: got %h required 5678", insn_a); end
    idle(2);
  endtask

  task automatic test_async_reset();
    rdy_a = 1'b1;
    qb.push_back('{16'h1237, 16'h0, 1'b0});
    beat_a(4'h1); beat_a(4'h2); beat_a(4'h3); beat_a(4'h7);
    beat_a(4'hD); beat_a(4'hE);
    n_checks++;
    if (cnt_a !== 2'd0) begin n_fail++; $display("FAIL s_imm_cnt: got %0d required 0", cnt_a); end
    #2;
    rst = 1'b1;
    #1;
    n_checks += 5;
    if (ovld_a !== 1'b0)    begin n_fail++; $display("FAIL arst_vld: got %b required 0", ovld_a); end
    if (insn_a !== 16'h0)   begin n_fail++; $display("FAIL arst_insn: got %h required 0000", insn_a); end
    if (immv_a !== 1'b0)    begin n_fail++; $display("FAIL arst_imm_vld: got %b required 0", immv_a); end
    if (cnt_a !== 2'd0)     begin n_fail++; $display("FAIL arst_cnt: got %0d required 0", cnt_a); end
    if (enc_rdy_a !== 1'b1) begin n_fail++; $display("FAIL arst_enc_rdy: got %b required 1", enc_rdy_a); end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    qa.push_back('{16'hCAFE, 16'h0, 1'b0});
    qb.push_back('{16'hCAFE, 16'h0, 1'b0});
    beat_a(4'hC); beat_a(4'hA); beat_a(4'hF); beat_a(4'hE);
    n_checks += 2;
    if (insn_a !== 16'hCAFE) begin n_fail++; $display("FAIL post_rst_insn: got %h required cafe", insn_a); end
    if (immv_a !== 1'b0)     begin n_fail++; $display("FAIL post_rst_imm_vld: got %b required 0", immv_a); end
    idle(2);
  endtask

  initial begin
    fork
      forever begin
        @(negedge clk);
        if (!rst && !flush_a && ovld_a && rdy_a) begin
          n_checks++;
          if (qa.size() == 0) begin
            n_fail++;
            $display("FAIL pop_a: unexpected entry insn=%h imm=%h", insn_a, imm_a);
          end else begin
            ea = qa.pop_front();
            if ({insn_a, imm_a, immv_a} !== ea) begin
              n_fail++;
              $display("FAIL pop_a: got insn=%h imm=%h imm_vld=%b required insn=%h imm=%h imm_vld=%b",
                       insn_a, imm_a, immv_a, ea.insn, ea.imm, ea.immv);
            end
          end
        end
        if (!rst && !flush_a && ovld_b && rdy_a) begin
          n_checks++;
          if (qb.size() == 0) begin
            n_fail++;
            $display("FAIL pop_b: unexpected entry insn=%h imm=%h", insn_b, imm_b);
          end else begin
            eb = qb.pop_front();
            if ({insn_b, imm_b, immv_b} !== eb) begin
              n_fail++;
              $display("FAIL pop_b: got insn=%h imm=%h imm_vld=%b required insn=%h imm=%h imm_vld=%b",
                       insn_b, imm_b, immv_b, eb.insn, eb.imm, eb.immv);
            end
          end
        end
        if (!rst && ovld_c && rdy_c) begin
          n_checks++;
          if (qc.size() == 0) begin
            n_fail++;
            $display("FAIL pop_c: unexpected entry insn=%h", insn_c);
          end else begin
            ec = qc.pop_front();
            if ({insn_c, imm_c, immv_c} !== ec) begin
              n_fail++;
              $display("FAIL pop_c: got insn=%h imm=%h imm_vld=%b required insn=%h imm=%h imm_vld=%b",
                       insn_c, imm_c, immv_c, ec.insn, ec.imm, ec.immv);
            end
          end
        end
      end
    join_none

    test_reset();
    test_basic();
    test_imm();
    test_lsb_first();
    test_back_to_back();
    test_flush();
    test_async_reset();

    n_checks += 3;
    if (qa.size() != 0) begin n_fail++; $display("FAIL leftover_a: %0d entries required 0", qa.size()); end
    if (qb.size() != 0) begin n_fail++; $display("FAIL leftover_b: %0d entries required 0", qb.size()); end
    if (qc.size() != 0) begin n_fail++; $display("FAIL leftover_c: %0d entries required 0", qc.size()); end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/idli_insn_deser_m.md
Name: idli_insn_deser_m

Overview:
- Parametrised successor to the 4b-per-cycle instruction front end.
- Assembles a serial instruction stream of LANE_W bits per beat (single, dual, quad or octal SQI modes) into complete 16b instruction words.
- Attaches the trailing 16b immediate when the instruction's C field selects one.
- Buffers complete entries in a DEPTH-deep FIFO with valid/ready handshakes on both sides, so decode can consume whole words and stall fetch.

Parameters:
- LANE_W, 4, bits per input beat; legal values 1, 2, 4, 8. WORD_W % LANE_W == 0.
- WORD_W, 16, instruction/immediate word width.
- DEPTH, 2, FIFO entries; ≥1.
- MSB_FIRST, 1, 1: the first beat carries the word MSBs. 0: the first beat carries the LSBs.
- IMM_EN, 1, 1: detect and capture a trailing immediate. 0: never expect one.

Ports:
- i_ids_gck  in  1  clock
- i_ids_rst  in  1  reset; one clock, reset is asynchronous and active-high
- i_ids_enc  in  LANE_W  serial encoding beat
- i_ids_enc_vld  in  1  beat valid
- o_ids_enc_rdy  out  1  beat accepted when vld & rdy
- i_ids_flush  in  1  redirect; discard all buffered and partial state
- o_ids_vld  out  1  FIFO head valid
- i_ids_rdy  in  1  consumer pops head when vld & rdy
- o_ids_insn  out  WORD_W  head instruction word
- o_ids_imm  out  WORD_W  head immediate; 0 when none
- o_ids_imm_vld  out  1  head carries an immediate
- o_ids_cnt  out  $clog2(DEPTH+1)  FIFO occupancy

Behaviour:
- BEATS = WORD_W/LANE_W.
- Beat counter: 0..BEATS-1, increments on each accepted beat, wraps to 0 after the last beat.
- Shift register:
  - MSB_FIRST=1: shift left by LANE_W, beat inserted at the LSBs.
  - MSB_FIRST=0: shift right, beat inserted at the MSBs.
- The assembled word is the shift register with the current beat included on the last beat.
- Assembly FSM:
  - S_INSN, on the last beat:
    - If IMM_EN and assembled[2:0]==3'b111: latch the word as pending insn, go to S_IMM.
    - Otherwise push {insn=word, imm=0, imm_vld=0} and stay in S_INSN.
  - S_IMM, on the last beat: push {pending insn, imm=word, imm_vld=1}, go to S_INSN.
  - No other transitions. The counter does not advance without an accepted beat.
- o_ids_enc_rdy = (o_ids_cnt != DEPTH).
  - Registered-only dependency; no combinational path from i_ids_rdy or i_ids_enc_vld.
  - Partial words stall while the FIFO is full.
- FIFO: circular buffer with read/write pointers mod DEPTH; first-word fall-through.
  - o_ids_vld = (cnt != 0).
  - Head outputs are driven from storage at the read pointer.
  - Push and pop in the same cycle: count unchanged, both pointers advance.
  - Push into an empty FIFO: visible on o_ids_vld the next cycle (1-cycle latency from the last beat to valid).
  - Pop when empty is impossible, since vld=0.
- Head outputs are held stable while vld & !rdy.
- Flush (synchronous): cnt←0, pointers←0, beat counter←0, FSM←S_INSN, pending insn discarded.
  - Flush has priority over a same-cycle push, pop or beat accept; a beat presented during flush is dropped.
  - The first beat after flush is treated as beat 0 of an instruction.
- Reset (async assert, sync release):
  - State: FSM S_INSN, beat counter 0, pointers 0, cnt 0, all storage 0.
  - Outputs: o_ids_vld 0, o_ids_insn 0, o_ids_imm 0, o_ids_imm_vld 0, o_ids_cnt 0, o_ids_enc_rdy 1.
  - Reset asserted mid-word or mid-immediate abandons the partial assembly.
- DEPTH=1: enc_rdy=0 whenever an entry is held, including the cycle it is popped; no bypass.
- X on i_ids_enc with i_ids_enc_vld=0 must not propagate to any state.

Test Plan:
- LANE_W=4, MSB_FIRST=1; beats 0x1,0x2,0x3,0x4 on consecutive cycles, i_ids_rdy=1 -> one cycle after the 4th beat: vld=1, insn=0x1234, imm_vld=0, imm=0x0000; entry popped next cycle, cnt back to 0.
- LANE_W=4; beats A,B,C,F,D,E,A,D -> a single entry with insn=0xABCF, imm=0xDEAD, imm_vld=1; no entry is pushed after the 4th beat. With IMM_EN=0, the same stream gives two entries: 0xABCF then 0xDEAD, both imm_vld=0.
- LANE_W=1 and MSB_FIRST=0; 16 beats giving 0x8001 LSB first -> insn=0x8001 after the 16th beat, enc_rdy stays 1 throughout.
- DEPTH=2, i_ids_rdy=0; stream three instructions 0x1111,0x2222,0x3333 -> cnt reaches 2, enc_rdy drops to 0, the third word's beats are not accepted. Raise rdy -> pops 0x1111 then 0x2222 in order, 0x3333 then completes.
- Flush after two beats of a word, with one entry buffered -> next cycle cnt=0, vld=0. Beats 0x5,0x6,0x7,0x8 then yield insn=0x5678, with no remnant of the earlier beats.
- Assert i_ids_rst asynchronously while in S_IMM after 2 immediate beats -> outputs take their reset values immediately. After release, beats 0xC,0xA,0xF,0xE yield insn=0xCAFE, imm_vld=0.
